// File: rtl/can_rec_arbiter_pkg.sv
// Shared types and constants for the CAN receive arbiter.
package can_arb_pkg;
    localparam int NUM_BUS_MAX = 16;
    localparam int SEL_W       = 5;
    localparam int DATA_W      = 76;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_DATA,
        UPLINK,
        GAP
    } arb_state_e;
endpackage

// File: rtl/can_rec_arbiter_if.sv
// Bus bundle between the arbiter, the CAN controllers and the uplink.
// master: arbiter side. slave: controllers/uplink side.
interface can_rec_arbiter_if
    import can_arb_pkg::*;
#(
    parameter int NUM_BUS = can_arb_pkg::NUM_BUS_MAX,
    parameter int DATA_W  = can_arb_pkg::DATA_W
);
    logic [SEL_W-1:0]   n_buses;
    logic [NUM_BUS-1:0] irq_can_rec;
    logic               rd_req;
    logic               rd_done;
    logic [DATA_W-1:0]  rd_data;
    logic [SEL_W-1:0]   can_rec_select;
    logic               busy;
    logic [DATA_W-1:0]  data_rec_uplink;
    logic               uplink_valid;
    logic               uplink_ready;
    logic               timeout_err;

    modport master (
        input  n_buses, irq_can_rec, rd_done, rd_data, uplink_ready,
        output rd_req, can_rec_select, busy, data_rec_uplink, uplink_valid, timeout_err
    );

    modport slave (
        output n_buses, irq_can_rec, rd_done, rd_data, uplink_ready,
        input  rd_req, can_rec_select, busy, data_rec_uplink, uplink_valid, timeout_err
    );
endinterface

// File: rtl/can_rec_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or above ptr within
// 0..n_buses, wrapping to the lowest set bit when nothing is found above.
module rr_pick
    import can_arb_pkg::*;
(
    input  logic [NUM_BUS_MAX-1:0] mask,
    input  logic [SEL_W-1:0]       ptr,
    input  logic [SEL_W-1:0]       n_buses,
    output logic                   found,
    output logic [SEL_W-1:0]       idx
);
    logic [SEL_W-1:0] lim;
    logic [SEL_W-1:0] start;

    // Two passes: upward from ptr, then wrap-around from bus 0
    always_comb begin
        lim   = (n_buses > SEL_W'(NUM_BUS_MAX - 1)) ? SEL_W'(NUM_BUS_MAX - 1) : n_buses;
        start = (ptr > lim) ? '0 : ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_BUS_MAX - 1; i >= 0; i--) begin
            if (mask[i] && (SEL_W'(i) <= lim) && (SEL_W'(i) >= start)) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
        end
        if (!found) begin
            for (int i = NUM_BUS_MAX - 1; i >= 0; i--) begin
                if (mask[i] && (SEL_W'(i) <= lim)) begin
                    found = 1'b1;
                    idx   = SEL_W'(i);
                end
            end
        end
    end
endmodule

// File: rtl/can_rec_arbiter.sv
// Round-robin scheduler sharing the uplink receive path between CAN buses.
// Optional per-bus statistics counters: define CAN_REC_ARB_STATS_EN.
module can_rec_arbiter #(
    parameter int NUM_BUS     = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int DATA_W      = can_arb_pkg::DATA_W
) (
    input  logic clk,
    input  logic rst,
`ifdef CAN_REC_ARB_STATS_EN
    input  logic [4:0]  stat_sel,
    output logic [15:0] stat_frames,
    output logic [7:0]  stat_timeouts,
`endif
    can_rec_arbiter_if.master bus
);
    import can_arb_pkg::*;

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

    arb_state_e        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  n_q, n_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              rd_req, timeout, xfer;

    logic [NUM_BUS_MAX-1:0] irq_ext;
    logic                   pick_found;
    logic [SEL_W-1:0]       pick_idx;

    assign irq_ext = NUM_BUS_MAX'(bus.irq_can_rec);

    rr_pick u_pick (
        .mask    (irq_ext),
        .ptr     (ptr_q),
        .n_buses (bus.n_buses),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Next-state and transaction control
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        n_d     = n_q;
        wd_d    = wd_q;
        data_d  = data_q;
        valid_d = valid_q;
        rd_req  = 1'b0;
        timeout = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    n_d     = bus.n_buses;
                    state_d = READ;
                end
            end
            READ: begin
                rd_req  = 1'b1;
                wd_d    = '0;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.rd_done) begin
                    data_d  = bus.rd_data;
                    valid_d = 1'b1;
                    state_d = UPLINK;
                end else if (wd_q == WD_MAX) begin
                    timeout = 1'b1;
                    state_d = GAP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            UPLINK: begin
                if (valid_q && bus.uplink_ready) begin
                    xfer    = 1'b1;
                    valid_d = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                // n_q is the bus limit captured at grant time
                ptr_d   = ((sel_q == n_q) || (sel_q == SEL_W'(NUM_BUS_MAX - 1))) ? '0 : sel_q + SEL_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            n_q     <= '0;
            wd_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            n_q     <= n_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.rd_req          = rd_req;
    assign bus.can_rec_select  = sel_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.data_rec_uplink = data_q;
    assign bus.uplink_valid    = valid_q;
    assign bus.timeout_err     = timeout;

`ifdef CAN_REC_ARB_STATS_EN
    logic [15:0] frames_q [NUM_BUS_MAX];
    logic [15:0] frames_d [NUM_BUS_MAX];
    logic [7:0]  touts_q  [NUM_BUS_MAX];
    logic [7:0]  touts_d  [NUM_BUS_MAX];

    // Saturating per-bus counters for delivered frames and timeouts
    always_comb begin
        frames_d = frames_q;
        touts_d  = touts_q;
        if (xfer && (frames_q[sel_q[3:0]] != 16'hFFFF))
            frames_d[sel_q[3:0]] = frames_q[sel_q[3:0]] + 16'd1;
        if (timeout && (touts_q[sel_q[3:0]] != 8'hFF))
            touts_d[sel_q[3:0]] = touts_q[sel_q[3:0]] + 8'd1;
    end

    // Counter storage
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '{default: '0};
            touts_q  <= '{default: '0};
        end else begin
            frames_q <= frames_d;
            touts_q  <= touts_d;
        end
    end

    assign stat_frames   = (stat_sel < 5'd16) ? frames_q[stat_sel[3:0]] : '0;
    assign stat_timeouts = (stat_sel < 5'd16) ? touts_q[stat_sel[3:0]] : '0;
`endif
endmodule

// File: tb/tb_can_rec_arbiter.sv
// Self-checking bench for can_rec_arbiter with a round-robin reference model.
module tb_can_rec_arbiter;
    localparam int TO = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    can_rec_arbiter_if ifc();

`ifdef CAN_REC_ARB_STATS_EN
    logic [4:0]  stat_sel = '0;
    logic [15:0] stat_frames;
    logic [7:0]  stat_timeouts;
`endif

    can_rec_arbiter #(.NUM_BUS(16), .TIMEOUT_CYC(TO), .DATA_W(76)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef CAN_REC_ARB_STATS_EN
        .stat_sel      (stat_sel),
        .stat_frames   (stat_frames),
        .stat_timeouts (stat_timeouts),
`endif
        .bus           (ifc)
    );

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;

    // Reference: scan buses start, start+1, ... modulo (n+1)
    function automatic int model_pick(input logic [15:0] req, input int ptr, input int n);
        int start;
        start = (ptr > n) ? 0 : ptr;
        for (int k = 0; k <= n; k++) begin
            if (req[(start + k) % (n + 1)]) return (start + k) % (n + 1);
        end
        return -1;
    endfunction

    function automatic int model_next(input int g, input int n);
        return (g + 1) % (n + 1);
    endfunction

    function automatic logic [75:0] rand76();
        return {12'($urandom), $urandom, $urandom};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifc.irq_can_rec  = '0;
        ifc.rd_done      = 1'b0;
        ifc.rd_data      = '0;
        ifc.uplink_ready = 1'b0;
        ifc.n_buses      = 5'd15;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    task automatic wait_rd_req(input int budget, output int cyc, output logic [4:0] sel);
        cyc = -1;
        sel = '0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (ifc.rd_req === 1'b1) begin
                cyc = i;
                sel = ifc.can_rec_select;
                break;
            end
        end
    endtask

    // Called at the READ negedge; returns at the GAP negedge
    task automatic serve(input logic [75:0] d, input int rdy_wait,
                         output logic rq2, output logic v, output logic [75:0] q);
        @(negedge clk);
        rq2 = ifc.rd_req;
        ifc.rd_done = 1'b1;
        ifc.rd_data = d;
        @(negedge clk);
        ifc.rd_done = 1'b0;
        ifc.rd_data = '0;
        repeat (rdy_wait) @(negedge clk);
        v = ifc.uplink_valid;
        q = ifc.data_rec_uplink;
        ifc.uplink_ready = 1'b1;
        @(negedge clk);
        ifc.uplink_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ifc.rd_req, ifc.can_rec_select, ifc.busy, ifc.uplink_valid, ifc.timeout_err} !== 9'd0 ||
            ifc.data_rec_uplink !== 76'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b sel=%0d busy=%b vld=%b to=%b data=%h, expected all zero",
                     ifc.rd_req, ifc.can_rec_select, ifc.busy, ifc.uplink_valid, ifc.timeout_err, ifc.data_rec_uplink);
        end
    endtask

    task automatic test_single();
        int c; logic [4:0] s; logic rq2, v; logic [75:0] q;
        do_reset();
        ifc.n_buses     = 5'd15;
        ifc.irq_can_rec = 16'h0010;
        wait_rd_req(10, c, s);
        checks++;
        if (c !== 1) begin errors++; $display("FAIL single_latency: got %0d cycles, expected 1", c); end
        checks++;
        if (s !== 5'd4) begin errors++; $display("FAIL single_select: got %0d, expected 4", s); end
        ifc.irq_can_rec = '0;
        serve(76'hA5, 2, rq2, v, q);
        checks++;
        if (rq2 !== 1'b0) begin errors++; $display("FAIL single_rdreq_pulse: rd_req=%b in WAIT_DATA, expected 0", rq2); end
        checks++;
        if (v !== 1'b1 || q !== 76'hA5) begin errors++; $display("FAIL single_uplink: got vld=%b data=%h, expected 1 / a5", v, q); end
        checks++;
        if (ifc.uplink_valid !== 1'b0 || ifc.busy !== 1'b1) begin
            errors++; $display("FAIL single_gap: got vld=%b busy=%b, expected 0 / 1", ifc.uplink_valid, ifc.busy);
        end
        @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b0 || ifc.can_rec_select !== 5'd4 || ifc.rd_req !== 1'b0) begin
            errors++; $display("FAIL single_idle: got busy=%b sel=%0d req=%b, expected 0 / 4 / 0", ifc.busy, ifc.can_rec_select, ifc.rd_req);
        end
    endtask

    task automatic test_round_robin();
        int c, exp; logic [4:0] s; logic rq2, v; logic [75:0] q, d;
        int order [5] = '{2, 7, 15, 2, 7};
        do_reset();
        ifc.n_buses     = 5'd15;
        ifc.irq_can_rec = 16'h8084;
        for (int i = 0; i < 5; i++) begin
            wait_rd_req(20, c, s);
            exp = model_pick(16'h8084, m_ptr, 15);
            checks++;
            if (c < 0 || int'(s) != exp || int'(s) != order[i]) begin
                errors++; $display("FAIL rr_grant%0d: got %0d, expected %0d", i, s, order[i]);
            end
            d = rand76();
            serve(d, i, rq2, v, q);
            checks++;
            if (v !== 1'b1 || q !== d) begin errors++; $display("FAIL rr_data%0d: got %h, expected %h", i, q, d); end
            m_ptr = model_next(exp, 15);
        end
        ifc.irq_can_rec = '0;
    endtask

    task automatic test_masking();
        int c, exp; logic [4:0] s; logic rq2, v; logic [75:0] q;
        int wrap_order [3] = '{0, 3, 0};
        do_reset();
        ifc.n_buses     = 5'd3;
        ifc.irq_can_rec = 16'h0202;
        for (int i = 0; i < 4; i++) begin
            wait_rd_req(20, c, s);
            checks++;
            if (c < 0 || s !== 5'd1) begin errors++; $display("FAIL mask_grant%0d: got %0d, expected 1", i, s); end
            serve(76'h1, 0, rq2, v, q);
        end
        do_reset();
        ifc.n_buses     = 5'd3;
        ifc.irq_can_rec = 16'h0009;
        for (int i = 0; i < 3; i++) begin
            wait_rd_req(20, c, s);
            exp = model_pick(16'h0009, m_ptr, 3);
            checks++;
            if (c < 0 || int'(s) != exp || int'(s) != wrap_order[i]) begin
                errors++; $display("FAIL wrap_grant%0d: got %0d, expected %0d", i, s, wrap_order[i]);
            end
            serve(76'h2, 0, rq2, v, q);
            m_ptr = model_next(exp, 3);
        end
        ifc.irq_can_rec = '0;
    endtask

    task automatic test_timeout();
        int c, n; logic [4:0] s; logic vbad;
        do_reset();
        ifc.n_buses     = 5'd15;
        ifc.irq_can_rec = 16'h0220;
        wait_rd_req(20, c, s);
        checks++;
        if (s !== 5'd5) begin errors++; $display("FAIL to_grant: got %0d, expected 5", s); end
        n = -1;
        vbad = 1'b0;
        for (int i = 1; i <= TO + 20; i++) begin
            @(negedge clk);
            if (ifc.uplink_valid !== 1'b0) vbad = 1'b1;
            if (ifc.timeout_err === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n != TO) begin errors++; $display("FAIL to_delay: got %0d cycles, expected %0d", n, TO); end
        checks++;
        if (vbad !== 1'b0) begin errors++; $display("FAIL to_valid: uplink_valid rose, expected 0"); end
        @(negedge clk);
        checks++;
        if (ifc.timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b one cycle later, expected 0", ifc.timeout_err); end
        m_ptr = model_next(5, 15);
        wait_rd_req(20, c, s);
        checks++;
        if (c < 0 || int'(s) != model_pick(16'h0220, m_ptr, 15)) begin
            errors++; $display("FAIL to_next: got %0d, expected %0d", s, model_pick(16'h0220, m_ptr, 15));
        end
        ifc.irq_can_rec = '0;
    endtask

    task automatic test_backpressure();
        int c, bad; logic [4:0] s; logic [75:0] d;
        do_reset();
        ifc.n_buses     = 5'd15;
        ifc.irq_can_rec = 16'h1008;
        wait_rd_req(20, c, s);
        d = rand76();
        @(negedge clk);
        ifc.rd_done = 1'b1;
        ifc.rd_data = d;
        @(negedge clk);
        ifc.rd_done = 1'b0;
        ifc.rd_data = rand76();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (ifc.uplink_valid !== 1'b1 || ifc.data_rec_uplink !== d || ifc.rd_req !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles, expected 0", bad); end
        ifc.uplink_ready = 1'b1;
        @(negedge clk);
        ifc.uplink_ready = 1'b0;
        checks++;
        if (ifc.uplink_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got vld=%b, expected 0", ifc.uplink_valid); end
        ifc.irq_can_rec = '0;
    endtask

    task automatic test_reset_mid();
        int c; logic [4:0] s; logic rq2, v; logic [75:0] q;
        do_reset();
        ifc.n_buses     = 5'd15;
        ifc.irq_can_rec = 16'h0108;
        wait_rd_req(20, c, s);
        serve(76'h3, 0, rq2, v, q);
        wait_rd_req(20, c, s);
        checks++;
        if (s !== 5'd8) begin errors++; $display("FAIL rst_pre_grant: got %0d, expected 8", s); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ifc.rd_req, ifc.can_rec_select, ifc.busy, ifc.uplink_valid, ifc.timeout_err} !== 9'd0 ||
            ifc.data_rec_uplink !== 76'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got req=%b sel=%0d busy=%b vld=%b, expected all zero",
                     ifc.rd_req, ifc.can_rec_select, ifc.busy, ifc.uplink_valid);
        end
        wait_rd_req(20, c, s);
        checks++;
        if (c < 0 || s !== 5'd3) begin errors++; $display("FAIL rst_restart: got %0d, expected 3", s); end
        ifc.irq_can_rec = '0;
    endtask

    task automatic test_random();
        int c, exp, n, n_g;
        logic [4:0] s; logic rq2, v; logic [75:0] q, d; logic [15:0] req;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            n   = $urandom_range(0, 15);
            req = 16'($urandom);
            if ((req & ((17'h1 << (n + 1)) - 1)) == 0) req[$urandom_range(0, n)] = 1'b1;
            ifc.n_buses     = 5'(n);
            ifc.irq_can_rec = req;
            exp = model_pick(req, m_ptr, n);
            n_g = n;
            wait_rd_req(20, c, s);
            checks++;
            if (c < 0 || int'(s) != exp) begin
                errors++; $display("FAIL rand_grant%0d: got %0d, expected %0d (n=%0d req=%h)", it, s, exp, n, req);
            end
            d = rand76();
            serve(d, $urandom_range(0, 3), rq2, v, q);
            checks++;
            if (v !== 1'b1 || q !== d) begin errors++; $display("FAIL rand_data%0d: got %h, expected %h", it, q, d); end
            m_ptr = model_next(exp, n_g);
        end
        ifc.irq_can_rec = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        ifc.irq_can_rec  = '0;
        ifc.rd_done      = 1'b0;
        ifc.rd_data      = '0;
        ifc.uplink_ready = 1'b0;
        ifc.n_buses      = 5'd15;
        test_reset();
        test_single();
        test_round_robin();
        test_masking();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
